// File: rtl/scroll_display_ctrl_pkg.sv
// Shared types and constants for the scrolling nibble display controller.
// Holds the FSM encoding, buffer geometry and the step-rate table.
package scroll_display_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int NIBBLES = 4;
    localparam int NIB_W   = 4;
    localparam int BUF_W   = NIBBLES * NIB_W;
    localparam int DIV_W   = 3;
    localparam int CNT_W   = 2;

    // Last base-tick index of a step for each speed_sel (1/2/4/8 ticks)
    function automatic logic [DIV_W-1:0] step_last(input logic [1:0] sel);
        logic [DIV_W-1:0] r;
        case (sel)
            2'd0:    r = 3'd0;
            2'd1:    r = 3'd1;
            2'd2:    r = 3'd3;
            default: r = 3'd7;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/scroll_display_ctrl_tick_gen.sv
// Base-tick prescaler: counts 0..TICK_DIV-1 while enabled.
// Emits a one-cycle tick on the last count; clr wins over en.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/scroll_display_ctrl.sv
// Scrolling four-nibble message controller feeding two 7-seg decoders.
// Rotates the message one nibble per step at a selectable rate.
module scroll_display_ctrl
    import scroll_display_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BUF_W-1:0] msg_data,
    input  logic             msg_valid,
    output logic             msg_ready,
    input  logic             dir,
    input  logic [1:0]       speed_sel,
    input  logic             pause,
    input  logic             repeat_mode,
    output logic [NIB_W-1:0] digit_lo,
    output logic [NIB_W-1:0] digit_hi,
    output logic             seg_en,
    output logic             busy
);

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    state_e           state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xfer;
    logic             tick;

    // Assert passes straight through; release is delayed two clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];
    assign msg_ready = 1'b1;
    assign xfer      = msg_valid && msg_ready;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_int_n),
        .en   ((state_q == RUN) && !pause),
        .clr  (xfer),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            buf_d   = msg_data;
            div_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
        end else if (tick) begin
            if (div_q >= step_last(speed_sel)) begin
                div_d = '0;
                cnt_d = cnt_q + CNT_W'(1);
                buf_d = dir ? {buf_q[BUF_W-NIB_W-1:0], buf_q[BUF_W-1:BUF_W-NIB_W]}
                            : {buf_q[NIB_W-1:0], buf_q[BUF_W-1:NIB_W]};
                if ((cnt_q == CNT_W'(NIBBLES - 1)) && !repeat_mode) begin
                    state_d = IDLE;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
        end
    end

    assign digit_lo = buf_q[NIB_W-1:0];
    assign digit_hi = buf_q[2*NIB_W-1:NIB_W];
    assign busy     = (state_q == RUN);
    assign seg_en   = (state_q == RUN);

endmodule

// File: doc/scroll_display_ctrl.md
SCROLL_DISPLAY_CTRL -- requirements
Module: scroll_display_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, meaning clk cycles per base tick (minimum 2).
REQ-002 SHALL have port clk  input  1  rising-edge system clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port msg_data  input  16  four-nibble message, nibble 0 = [3:0].
REQ-005 SHALL have port msg_valid  input  1  load request; transfer occurs when msg_valid and msg_ready are both high on a rising edge.
REQ-006 SHALL have port msg_ready  output  1  controller can accept a message.
REQ-007 SHALL have port dir  input  1  0 = rotate right by one nibble per step, 1 = rotate left.
REQ-008 SHALL have port speed_sel  input  2  one step every 1/2/4/8 base ticks for values 0/1/2/3.
REQ-009 SHALL have port pause  input  1  freezes scrolling while high.
REQ-010 SHALL have port repeat  input  1  1 = scroll continuously, 0 = stop after one revolution.
REQ-011 SHALL have port digit_lo  output  4  nibble for low display, equal to buf[3:0].
REQ-012 SHALL have port digit_hi  output  4  nibble for high display, equal to buf[7:4].
REQ-013 SHALL have port seg_en  output  1  display enable for both decoders.
REQ-014 SHALL have port busy  output  1  high while in RUN.

Function
REQ-015 SHALL implement FSM states IDLE and RUN; reset enters IDLE.
REQ-016 IDLE: seg_en=0, busy=0, msg_ready=1, buf unchanged.
REQ-017 A transfer in either state SHALL, at that edge, load buf<=msg_data, clear the prescaler, step divider and step count, and enter RUN; seg_en=1 from the next cycle.
REQ-018 msg_ready SHALL be 1 in both states (the block never back-pressures); a transfer in RUN restarts the message.
REQ-019 Prescaler SHALL count 0..TICK_DIV-1 in RUN when pause=0 and emit a one-cycle base tick at TICK_DIV-1.
REQ-020 Step divider SHALL count base ticks and emit a step on the 2^speed_sel-th tick; speed_sel is sampled on each tick.
REQ-021 On a step: dir=0 -> buf<={buf[3:0],buf[15:4]}; dir=1 -> buf<={buf[11:0],buf[15:12]}; step count (2-bit) increments modulo 4.
REQ-022 When a step wraps the step count from 3 to 0 and repeat=0, the FSM SHALL enter IDLE after that rotation completes (buf is then back to the loaded value).
REQ-023 When pause=1, the prescaler, step divider, buf and step count SHALL hold; seg_en stays 1.
REQ-024 Transfer and step on the same edge: the transfer wins and the step is discarded.
REQ-025 A dir change SHALL take effect on the next step; it SHALL NOT reset the step count.
REQ-026 digit_lo and digit_hi SHALL be registered-source outputs with no combinational path from inputs.

Reset
REQ-027 rst_n low SHALL asynchronously set state=IDLE, buf=16'h0000, all counters=0, seg_en=0, busy=0, msg_ready=1, digit_lo=digit_hi=0.
REQ-028 Reset release SHALL be synchronised internally (two-flop synchroniser) and SHALL abort any scroll in progress.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, RUN), NIBBLES=4 and the speed_sel-to-divider encoding.
REQ-030 The prescaler SHALL be a sub-module tick_gen (parameter TICK_DIV; inputs clk, rst_n, en, clr; output tick).
REQ-031 The existing seven-segment decoders SHALL be instantiated outside this block.

Verification (TICK_DIV=4)
REQ-032 Load 16'h2025, dir=0, speed_sel=0, repeat=1 -> digits (hi,lo) = 2,5 / 0,2 / 2,0 / 5,2 / 2,5 ..., one step every 4 cycles.
REQ-033 Same load, repeat=0 -> exactly 4 steps, then busy=0, seg_en=0, buf=16'h2025.
REQ-034 speed_sel=3, dir=1, load 16'h1234 -> first step 32 cycles after transfer, buf=16'h2341.
REQ-035 pause asserted for 10 cycles mid-run -> no buf change; the next step comes at the remaining count after release.
REQ-036 msg_valid on the same edge as a step -> new message loaded, no rotation, counters cleared.
REQ-037 rst_n pulsed low mid-scroll -> outputs reach reset values immediately (asynchronously, before the next clock edge); IDLE after release.
